bsg_front_side_bus_hop_in: RTL and testbench

BSG_FRONT_SIDE_BUS_HOP_IN -- requirements
Module: bsg_front_side_bus_hop_in

---
 rtl/bsg_front_side_bus_hop_in.sv | 91 +++++++++
 tb/tb_bsg_front_side_bus_hop_in.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bsg_front_side_bus_hop_in.sv
// Front-side bus hop input: 2-entry FIFO steering packets to local/next hop.
// Define BSG_FSB_HOP_IN_BROADCAST_EN to make the all-ones ID target both ports.
module bsg_front_side_bus_hop_in #(
  parameter int width_p    = 32,
  parameter int id_width_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [id_width_p-1:0]   my_id_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  output logic                    ready_o,
  output logic [1:0]              v_o,
  output logic [2*width_p-1:0]    data_o,
  input  logic [1:0]              yumi_i
);

  logic [width_p-1:0]    mem_r [2];
  logic                  head_r;
  logic                  tail_r;
  logic                  full_r;
  logic                  empty_r;
  logic [1:0]            sent_r;

  logic [width_p-1:0]    head_data;
  logic [id_width_p-1:0] head_id;
  logic [1:0]            target;
  logic [1:0]            consumed;
  logic                  enq;
  logic                  deq;

  assign head_data = mem_r[head_r];
  assign head_id   = head_data[width_p-1 -: id_width_p];

  always_comb begin
    target = 2'b10;
    if (head_id == my_id_i)
      target = 2'b01;
`ifdef BSG_FSB_HOP_IN_BROADCAST_EN
    if (&head_id)
      target = 2'b11;
`endif
  end

  // Hold ready low while reset is asserted, not just while full.
  assign ready_o  = ~full_r & reset_n_i;
  assign v_o      = {2{~empty_r}} & target & ~sent_r;
  assign data_o   = {head_data, head_data};

  assign consumed = sent_r | (yumi_i & v_o);
  assign enq      = v_i & ~full_r & reset_n_i;
  assign deq      = ~empty_r & ((target & ~consumed) == 2'b00);

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_r[tail_r] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      sent_r  <= 2'b00;
    end else begin
      if (enq)
        tail_r <= ~tail_r;
      if (deq)
        head_r <= ~head_r;
      unique case ({enq, deq})
        2'b10: begin
          empty_r <= 1'b0;
          full_r  <= (~tail_r == head_r);
        end
        2'b01: begin
          full_r  <= 1'b0;
          empty_r <= (~head_r == tail_r);
        end
        default: ;
      endcase
      sent_r <= deq ? 2'b00 : consumed;
    end
  end

  yumi_without_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (yumi_i & ~v_o) == 2'b00
  );

endmodule

// File: tb/tb_bsg_front_side_bus_hop_in.sv
// Randomized bench for bsg_front_side_bus_hop_in against a queue model.
// Honors BSG_FSB_HOP_IN_BROADCAST_EN the same way the design does.
module tb_bsg_front_side_bus_hop_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  my_id;
  logic        v_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic [1:0]  v_o;
  logic [63:0] data_o;
  logic [1:0]  yumi;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_data[$];
  logic [1:0]  q_left[$];

  always #5 clk = ~clk;

  bsg_front_side_bus_hop_in #(.width_p(32), .id_width_p(4)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .my_id_i   (my_id),
    .v_i       (v_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .yumi_i    (yumi)
  );

  function automatic logic [1:0] tgt(logic [31:0] d, logic [3:0] id);
    logic [3:0] pid;
    pid = d[31:28];
`ifdef BSG_FSB_HOP_IN_BROADCAST_EN
    if (pid == 4'hF) return 2'b11;
`endif
    return (pid == id) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    // called at a negedge; reset lands off the clock edge
    v_i  = 1'b0;
    yumi = 2'b00;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_v_o", v_o, 2'b00);
    chk("rst_ready", ready_o, 1'b0);
    q_data.delete();
    q_left.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", ready_o, 1'b1);
    chk("post_rst_v_o", v_o, 2'b00);
  endtask

  task automatic step(int p_v, int p_y);
    logic [1:0] ev;
    logic [1:0] left;
    logic       acc;
    int         sel;
    ev = (q_left.size() != 0) ? q_left[0] : 2'b00;
    chk("v_o", v_o, ev);
    chk("ready_o", ready_o, q_data.size() < 2);
    if (q_data.size() != 0) begin
      chk("data_lo", data_o[31:0], q_data[0]);
      chk("data_hi", data_o[63:32], q_data[0]);
    end
    v_i    = ($urandom_range(99) < p_v);
    data_i = $urandom;
    sel    = $urandom_range(3);
    case (sel)
      0: data_i[31:28] = my_id;
      1: data_i[31:28] = 4'hF;
      2: data_i[31:28] = my_id + 4'd1;
      default: ;
    endcase
    yumi[0] = ev[0] & ($urandom_range(99) < p_y);
    yumi[1] = ev[1] & ($urandom_range(99) < p_y);
    @(posedge clk);
    acc = v_i && (q_data.size() < 2);
    if (ev != 2'b00) begin
      left = q_left[0] & ~yumi;
      q_left[0] = left;
      if (left == 2'b00) begin
        void'(q_data.pop_front());
        void'(q_left.pop_front());
      end
    end
    if (acc) begin
      q_data.push_back(data_i);
      q_left.push_back(tgt(data_i, my_id));
    end
    @(negedge clk);
  endtask

  task automatic run(int n, int p_v, int p_y);
    for (int i = 0; i < n; i++) step(p_v, p_y);
  endtask

  initial begin
    reset_n = 1'b1;
    my_id   = 4'd3;
    v_i     = 1'b0;
    data_i  = '0;
    yumi    = 2'b00;
    @(negedge clk);
    do_reset();

    run(40, 100, 100);
    run(6, 100, 0);
    run(6, 0, 100);
    run(300, 60, 50);
    run(5, 100, 20);
    do_reset();
    run(300, 70, 30);

    my_id = 4'd2;
    do_reset();
    run(300, 70, 60);

    my_id = 4'hF;
    do_reset();
    run(300, 70, 60);
    run(20, 100, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
